// File: rtl/zeroskip_tile_ctrl.sv
// zeroskip_tile_ctrl: tile-level sequencer for one zeroskip row engine.
// Latches the sparsity mode for a tile and gates the ZNZ/ACT sources into the engine.
// Injects an all-zero pad group in 8:32 mode when the group count is odd.
// Counts encoded output beats, flags the last one and pulses done at tile end.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both high.
// A valid never depends on the ready it is paired with.
module zeroskip_tile_ctrl #(
    parameter int DIN_W  = 32,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_start_i,
    input  logic [CNT_W-1:0]         cfg_num_groups_i,
    input  logic                     cfg_mode_i,
    output logic                     cfg_rdy_o,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic [DIN_W-1:0]         znz_src_din_i,
    input  logic                     znz_src_vld_i,
    output logic                     znz_src_rdy_o,
    input  logic [DIN_W*DATA_W-1:0]  act_src_din_i,
    input  logic                     act_src_vld_i,
    output logic                     act_src_rdy_o,
    output logic                     group_nz_sel_o,
    output logic [DIN_W-1:0]         znz_din_o,
    output logic [DIN_W*DATA_W-1:0]  act_din_o,
    output logic                     eng_in_vld_o,
    input  logic                     eng_in_rdy_i,
    input  logic                     eng_enc_vld_i,
    output logic                     eng_enc_rdy_o,
    output logic                     enc_vld_o,
    input  logic                     enc_rdy_i,
    output logic                     enc_last_o,
    output logic [2:0]               dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAD   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_n;
    logic [CNT_W-1:0]   r_e;
    logic [CNT_W-1:0]   r_in_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic               r_mode;

    logic               w_start;
    logic [CNT_W:0]     w_e_wide;
    logic               w_src_fire;
    logic               w_last_in;
    logic               w_pad_need;
    logic               w_out_act;
    logic               w_out_fire;
    logic               w_out_done;

    assign w_start    = (r_state == S_IDLE) && cfg_start_i;
    // 8:32 pairs two input groups per output beat, so round the count up.
    // One extra bit keeps N = 2^CNT_W-1 from overflowing before the shift.
    assign w_e_wide   = cfg_mode_i ? {1'b0, cfg_num_groups_i}
                                   : (({1'b0, cfg_num_groups_i} + (CNT_W+1)'(1)) >> 1);
    assign w_src_fire = (r_state == S_RUN) && znz_src_vld_i && act_src_vld_i && eng_in_rdy_i;
    assign w_last_in  = w_src_fire && ((r_in_cnt + CNT_W'(1)) == r_n);
    assign w_pad_need = ~r_mode & r_n[0];
    assign w_out_act  = ((r_state == S_RUN) || (r_state == S_PAD) || (r_state == S_DRAIN))
                        && (r_out_cnt != r_e);
    assign w_out_fire = w_out_act && eng_enc_vld_i && enc_rdy_i;
    // True when all E beats are out, counting a final beat firing this cycle.
    assign w_out_done = (r_out_cnt == r_e)
                        || (w_out_fire && ((r_out_cnt + CNT_W'(1)) == r_e));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tile configuration and group/beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n       <= '0;
            r_e       <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_mode    <= 1'b0;
        end else if (w_start) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            if (cfg_num_groups_i != '0) begin
                r_n    <= cfg_num_groups_i;
                r_e    <= w_e_wide[CNT_W-1:0];
                r_mode <= cfg_mode_i;
            end
        end else begin
            if (w_src_fire) begin
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end
            if (w_out_fire) begin
                r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (cfg_start_i) begin
                    w_state_nxt = (cfg_num_groups_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_last_in) begin
                    if (w_pad_need)      w_state_nxt = S_PAD;
                    else if (w_out_done) w_state_nxt = S_DONE;
                    else                 w_state_nxt = S_DRAIN;
                end
            end
            S_PAD: begin
                if (eng_in_rdy_i) begin
                    w_state_nxt = w_out_done ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_done) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Engine input gating, pad injection and encoded-output gating.
    always_comb begin
        cfg_rdy_o     = (r_state == S_IDLE);
        busy_o        = (r_state != S_IDLE);
        done_o        = (r_state == S_DONE);
        znz_src_rdy_o = 1'b0;
        act_src_rdy_o = 1'b0;
        eng_in_vld_o  = 1'b0;
        znz_din_o     = '0;
        act_din_o     = '0;
        if (r_state == S_RUN) begin
            znz_din_o     = znz_src_din_i;
            act_din_o     = act_src_din_i;
            eng_in_vld_o  = znz_src_vld_i & act_src_vld_i;
            znz_src_rdy_o = w_src_fire;
            act_src_rdy_o = w_src_fire;
        end else if (r_state == S_PAD) begin
            eng_in_vld_o  = 1'b1;
        end
        enc_vld_o     = w_out_act & eng_enc_vld_i;
        eng_enc_rdy_o = w_out_act & enc_rdy_i;
        enc_last_o    = w_out_act & eng_enc_vld_i & (r_out_cnt == (r_e - CNT_W'(1)));
    end

    assign group_nz_sel_o = r_mode;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_zeroskip_tile_ctrl.sv
// tb_zeroskip_tile_ctrl: directed tiles against a small engine model.
// Stimulus pushes expected engine-input groups and last flags into queues.
// The negedge monitor pops and compares them whenever the DUT transfers.
module tb_zeroskip_tile_ctrl;
  localparam int DIN_W  = 32;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int AW     = DIN_W * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start_i = 1'b0;
  logic [CNT_W-1:0]  cfg_num_groups_i = '0;
  logic              cfg_mode_i = 1'b0;
  logic              cfg_rdy_o, busy_o, done_o;
  logic [DIN_W-1:0]  znz_src_din_i = '0;
  logic              znz_src_vld_i = 1'b0;
  logic              znz_src_rdy_o;
  logic [AW-1:0]     act_src_din_i = '0;
  logic              act_src_vld_i = 1'b0;
  logic              act_src_rdy_o;
  logic              group_nz_sel_o;
  logic [DIN_W-1:0]  znz_din_o;
  logic [AW-1:0]     act_din_o;
  logic              eng_in_vld_o;
  logic              eng_in_rdy_i = 1'b1;
  logic              eng_enc_vld_i = 1'b0;
  logic              eng_enc_rdy_o;
  logic              enc_vld_o;
  logic              enc_rdy_i = 1'b1;
  logic              enc_last_o;
  logic [2:0]        dbg_state_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_out_cyc = -100;
  int src_fires = 0;
  int pending = 0;
  int half = 0;
  bit eng_mode16 = 1'b1;

  logic [DIN_W-1:0] in_z_q[$];
  logic [AW-1:0]    in_a_q[$];
  logic             exp_q[$];

  zeroskip_tile_ctrl #(.DIN_W(DIN_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start_i(cfg_start_i), .cfg_num_groups_i(cfg_num_groups_i), .cfg_mode_i(cfg_mode_i),
    .cfg_rdy_o(cfg_rdy_o), .busy_o(busy_o), .done_o(done_o),
    .znz_src_din_i(znz_src_din_i), .znz_src_vld_i(znz_src_vld_i), .znz_src_rdy_o(znz_src_rdy_o),
    .act_src_din_i(act_src_din_i), .act_src_vld_i(act_src_vld_i), .act_src_rdy_o(act_src_rdy_o),
    .group_nz_sel_o(group_nz_sel_o), .znz_din_o(znz_din_o), .act_din_o(act_din_o),
    .eng_in_vld_o(eng_in_vld_o), .eng_in_rdy_i(eng_in_rdy_i),
    .eng_enc_vld_i(eng_enc_vld_i), .eng_enc_rdy_o(eng_enc_rdy_o),
    .enc_vld_o(enc_vld_o), .enc_rdy_i(enc_rdy_i), .enc_last_o(enc_last_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset-free cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // engine model: drives encoded-output valid from its pending beat count
  always @(posedge clk) begin
    #1;
    eng_enc_vld_i = (pending > 0);
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
      half = 0;
    end else begin
      if (znz_src_rdy_o || act_src_rdy_o) begin
        chk("src_joint", {znz_src_rdy_o, act_src_rdy_o, znz_src_vld_i, act_src_vld_i, eng_in_rdy_i}, 5'b11111);
        src_fires++;
      end
      if (znz_src_vld_i && !act_src_vld_i)
        chk("znz_alone_rdy", {znz_src_rdy_o, act_src_rdy_o}, 2'b00);
      if (eng_in_vld_o && eng_in_rdy_i) begin
        if (in_z_q.size() == 0) fail_now("eng_in_unexpected");
        else begin
          chk("znz_din", znz_din_o, in_z_q.pop_front());
          chk("act_din", act_din_o, in_a_q.pop_front());
        end
        if (eng_mode16) pending++;
        else begin
          if (half == 1) pending++;
          half = 1 - half;
        end
      end
      if (eng_enc_vld_i && eng_enc_rdy_o) pending--;
      if (enc_last_o && !enc_vld_o) fail_now("last_without_vld");
      if (enc_vld_o && enc_rdy_i) begin
        if (exp_q.size() == 0) fail_now("enc_unexpected");
        else chk("enc_last", enc_last_o, exp_q.pop_front());
        last_out_cyc = cyc;
      end
    end
  end

  // driver tasks: enter and leave 1 time unit after a rising edge
  task automatic start_tile(input int n, input bit mode, input bit accept);
    cfg_start_i = 1'b1;
    cfg_num_groups_i = CNT_W'(n);
    cfg_mode_i = mode;
    if (accept) begin
      eng_mode16 = mode;
      src_fires = 0;
    end
    @(posedge clk); #1;
    cfg_start_i = 1'b0;
    cfg_mode_i = 1'b0;
  endtask

  task automatic send_group(input logic [DIN_W-1:0] z, input logic [AW-1:0] a, input int gap);
    int k = 0;
    int g = gap;
    bit fired = 1'b0;
    in_z_q.push_back(z);
    in_a_q.push_back(a);
    znz_src_din_i = z;
    act_src_din_i = a;
    znz_src_vld_i = 1'b1;
    act_src_vld_i = (g == 0);
    while (!fired && k < 100) begin
      @(negedge clk);
      fired = znz_src_rdy_o;
      @(posedge clk); #1;
      k++;
      if (g > 0) g--;
      act_src_vld_i = (g == 0);
    end
    znz_src_vld_i = 1'b0;
    act_src_vld_i = 1'b0;
    if (!fired) fail_now("send_group_timeout");
  endtask

  task automatic wait_done(input string name, input int exp_src, input bit gap_chk, output int lat);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      if (done_o) seen = 1'b1;
    end
    lat = k;
    chk({name, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      chk({name, "_src_fires"}, src_fires, exp_src);
      if (gap_chk) chk({name, "_done_gap"}, cyc - last_out_cyc, 1);
      chk({name, "_beats_left"}, exp_q.size(), 0);
      chk({name, "_groups_left"}, in_z_q.size(), 0);
      @(negedge clk);
      chk({name, "_done_after"}, {done_o, cfg_rdy_o, busy_o}, 3'b010);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // reset values
    #2;
    chk("rst_status", {cfg_rdy_o, busy_o, done_o, dbg_state_o}, 6'b100_000);
    chk("rst_eng", {eng_in_vld_o, znz_src_rdy_o, act_src_rdy_o, group_nz_sel_o}, 4'b0000);
    chk("rst_enc", {enc_vld_o, eng_enc_rdy_o, enc_last_o}, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: 16:32, N=4, no stalls
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    start_tile(4, 1'b1, 1'b1);
    chk("t1_sel", group_nz_sel_o, 1'b1);
    for (int i = 0; i < 4; i++)
      send_group(32'h1111_0000 + i, {8{32'hA000_0000 + i}}, 0);
    wait_done("t1", 4, 1'b1, lat);

    // T2: 8:32, N=4 -> E=2, no pad
    exp_q.push_back(0); exp_q.push_back(1);
    start_tile(4, 1'b0, 1'b1);
    chk("t2_sel", group_nz_sel_o, 1'b0);
    for (int i = 0; i < 4; i++)
      send_group(32'h2222_0000 + i, {8{32'hB000_0000 + i}}, 0);
    wait_done("t2", 4, 1'b1, lat);
    chk("t2_sel_end", group_nz_sel_o, 1'b0);

    // T3: 8:32, N=3 -> pad group, E=2; sources held valid during pad/drain
    exp_q.push_back(0); exp_q.push_back(1);
    start_tile(3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      send_group(32'h3333_0000 + i, {8{32'hC000_0000 + i}}, 0);
    in_z_q.push_back('0);
    in_a_q.push_back('0);
    znz_src_din_i = 32'hFFFF_FFFF;
    act_src_din_i = {AW{1'b1}};
    znz_src_vld_i = 1'b1;
    act_src_vld_i = 1'b1;
    wait_done("t3", 3, 1'b1, lat);
    znz_src_vld_i = 1'b0;
    act_src_vld_i = 1'b0;

    // T4: N=0 -> done next cycle, no source handshake
    znz_src_vld_i = 1'b1;
    act_src_vld_i = 1'b1;
    start_tile(0, 1'b0, 1'b1);
    wait_done("t4", 0, 1'b0, lat);
    chk("t4_latency", lat, 1);
    znz_src_vld_i = 1'b0;
    act_src_vld_i = 1'b0;

    // T5: 16:32, N=3, downstream stall, ACT lagging ZNZ, ignored start
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    start_tile(3, 1'b1, 1'b1);
    fork
      begin
        enc_rdy_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 enc_rdy_i = 1'b1;
      end
      begin
        send_group(32'h5555_0000, {8{32'hD000_0000}}, 0);
        start_tile(7, 1'b0, 1'b0);
        chk("t5_busy_after_ignored_start", {busy_o, group_nz_sel_o}, 2'b11);
        send_group(32'h5555_0001, {8{32'hD000_0001}}, 2);
        send_group(32'h5555_0002, {8{32'hD000_0002}}, 1);
      end
    join
    wait_done("t5", 3, 1'b1, lat);
    chk("t5_sel_end", group_nz_sel_o, 1'b1);

    // T6: async reset mid-tile, then a fresh N=2 tile
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    start_tile(4, 1'b1, 1'b1);
    send_group(32'h6666_0000, {8{32'hE000_0000}}, 0);
    send_group(32'h6666_0001, {8{32'hE000_0001}}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_status", {cfg_rdy_o, busy_o, done_o, dbg_state_o}, 6'b100_000);
    chk("t6_rst_eng", {eng_in_vld_o, znz_src_rdy_o, act_src_rdy_o, group_nz_sel_o}, 4'b0000);
    chk("t6_rst_enc", {enc_vld_o, eng_enc_rdy_o, enc_last_o}, 3'b000);
    exp_q.delete();
    in_z_q.delete();
    in_a_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(0); exp_q.push_back(1);
    start_tile(2, 1'b1, 1'b1);
    chk("t6_sel", group_nz_sel_o, 1'b1);
    send_group(32'h7777_0000, {8{32'hF000_0000}}, 0);
    send_group(32'h7777_0001, {8{32'hF000_0001}}, 0);
    wait_done("t6", 2, 1'b1, lat);

    repeat (3) @(posedge clk);
    chk("final_beats_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/zeroskip_tile_ctrl.md
# zeroskip_tile_ctrl

Tile-level sequencer that drives one zeroskip row engine (DIN_W-wide ZNZ/ACT input, M-wide encoded output) through a tile of `cfg_num_groups` activation groups. It latches the sparsity mode, gates the upstream ZNZ/ACT sources, and counts input groups. In 8:32 mode it injects an all-zero pad group so the engine's 8→16 combine bridge flushes when the group count is odd. It also counts encoded output beats, marks the last one, and signals tile completion.

## Interface
- `DIN_W`, 32, group width in elements (ZNZ bits / ACT bytes per engine input beat)
- `DATA_W`, 8, activation element width
- `CNT_W`, 16, width of group counters and `cfg_num_groups_i`
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `cfg_start_i` in 1: start request, sampled only in IDLE
- `cfg_num_groups_i` in CNT_W: groups in tile, sampled with start
- `cfg_mode_i` in 1: 0 = 8:32, 1 = 16:32, sampled with start
- `cfg_rdy_o` out 1: high in IDLE
- `busy_o` out 1: high in RUN, PAD, DRAIN, DONE
- `done_o` out 1: one-cycle tile completion pulse
- `znz_src_din_i` in DIN_W: upstream ZNZ mask
- `znz_src_vld_i` / `znz_src_rdy_o`: in 1 / out 1, upstream ZNZ handshake
- `act_src_din_i` in DIN_W×DATA_W: upstream activations
- `act_src_vld_i` / `act_src_rdy_o`: in 1 / out 1, upstream ACT handshake
- `group_nz_sel_o` out 1: engine mode select, registered
- `znz_din_o` out DIN_W; `act_din_o` out DIN_W×DATA_W: engine input data
- `eng_in_vld_o` out 1: engine input valid, drives both ZNZ and ACT valids
- `eng_in_rdy_i` in 1: engine input ready (engine ZNZ rdy, equal to ACT rdy)
- `eng_enc_vld_i` in 1; `eng_enc_rdy_o` out 1: engine encoded-output handshake
- `enc_vld_o` out 1; `enc_rdy_i` in 1; `enc_last_o` out 1: downstream encoded-output handshake; data bypasses this block

## Operation
- States: IDLE, RUN, PAD, DRAIN, DONE.
- IDLE
  - `cfg_start_i`=1 with N=`cfg_num_groups_i`≠0: latch N, latch mode into `group_nz_sel_o`, compute expected outputs E (N in 16:32; (N+1)>>1 in 8:32, computed at CNT_W+1 bits), clear counters, go to RUN.
  - Start with N=0: go to DONE directly.
- RUN
  - `eng_in_vld_o` = `znz_src_vld_i` & `act_src_vld_i`.
  - `znz_src_rdy_o` = `act_src_rdy_o` = both valids & `eng_in_rdy_i`. Joint transfer only; one source is never consumed alone.
  - Data passes through unchanged.
  - Each input fire increments in_cnt.
  - On the fire that makes in_cnt=N: go to PAD if mode 8:32 and N odd, else DRAIN.
- PAD
  - Drive `znz_din_o`=0, `act_din_o`=0, `eng_in_vld_o`=1; source rdys low.
  - On `eng_in_rdy_i` go to DRAIN.
- DRAIN
  - Engine input vld low.
  - When out_cnt=E (including the cycle the last beat fires), go to DONE.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- Output path, active in RUN/PAD/DRAIN only (out_cnt<E):
  - `enc_vld_o` = `eng_enc_vld_i`.
  - `eng_enc_rdy_o` = `enc_rdy_i`.
  - Each output fire increments out_cnt.
  - `enc_last_o` = `enc_vld_o` & (out_cnt=E−1).
  - Once out_cnt=E, and in IDLE/DONE, `enc_vld_o`=`eng_enc_rdy_o`=0.
- Outputs may fire while still in RUN; both counters run concurrently.
- `cfg_start_i` outside IDLE is ignored. `group_nz_sel_o` changes only on start acceptance, never mid-tile.
- Counters are CNT_W bits and do not wrap, because N ≤ 2^CNT_W−1.

## Timing
- Reset values:
  - state IDLE.
  - `cfg_rdy_o`=1.
  - `busy_o`, `done_o`, `enc_last_o`, `enc_vld_o`, `eng_enc_rdy_o`, `eng_in_vld_o`, source rdys: all 0.
  - `group_nz_sel_o`=0; counters 0.
- Start accepted at edge k → source rdy can be high from cycle k+1.
- Input pass-through is combinational, zero latency. No skid buffer: at most one group per cycle.
- N=0: `done_o` high in the cycle after start; no source or engine handshake occurs.
- `done_o` is high in the cycle after the final output fire (or after the last input fire if E outputs were already sent). `cfg_rdy_o` is high the following cycle.
- Reset asserted mid-tile: immediately returns to IDLE and clears all counters and outputs. Partial engine contents are the engine's responsibility.

## Test plan
- 16:32 mode, N=4, no stalls → 4 input fires in cycles 1–4; 4 output beats; `enc_last_o` only on beat 4; `done_o` one cycle after beat 4.
- 8:32 mode, N=4 → 4 input fires, no PAD visited, E=2, `enc_last_o` on beat 2, `group_nz_sel_o`=0 throughout.
- 8:32 mode, N=3 → 3 source fires, then one PAD beat with `znz_din_o`=0 and `act_din_o`=0, source rdys low during PAD; E=2 output beats; `done_o` pulse.
- Start with N=0 → `done_o` next cycle; `znz_src_rdy_o` never rises; `cfg_rdy_o` high again in the cycle after that.
- 16:32 mode, N=3, `enc_rdy_i` low for 5 cycles mid-tile and `act_src_vld_i` toggling while ZNZ is valid → no source consumed without both valids; no beat lost; `done_o` only after the 3rd beat. `cfg_start_i` during RUN with mode 0 → ignored, `group_nz_sel_o` stays 1.
- `rst_n` pulsed low in RUN after 2 of 4 fires → all outputs at reset values asynchronously. A new start with N=2 then completes normally with 2 beats.
